// File: rtl/bit_count_pkg.sv
// Shared types and constants for the sequential population-count block.
package bit_count_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

endpackage

// File: rtl/bit_count_slice.sv
// Combinational population count of a narrow slice of the operand.
module bit_count_slice #(
  parameter int WIDTH     = 4,
  parameter int OUT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [OUT_WIDTH-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + OUT_WIDTH'(bits[i]);
    end
  end

endmodule

// File: rtl/bit_count_seq.sv
// Multi-cycle ones/zeros counter: scans a captured operand BITS_PER_CYCLE bits
// per clock, LSB slice first, and publishes the total with a one-cycle done pulse.
module bit_count_seq
  import bit_count_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [DATA_WIDTH-1:0]           data,
  input  logic                            mode,
  input  logic                            clear,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(DATA_WIDTH+1)-1:0] bit_count
);

  localparam int COUNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam int SCAN_CYCLES = (BITS_PER_CYCLE == 0) ? 1 : DATA_WIDTH / BITS_PER_CYCLE;
  localparam int IDX_WIDTH   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int SLICE_CW    = $clog2(BITS_PER_CYCLE + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SCAN_CYCLES - 1);

  if ((BITS_PER_CYCLE == 0) ? 1'b1 : ((DATA_WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("bit_count_seq: BITS_PER_CYCLE must be nonzero and divide DATA_WIDTH");
  end

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   data_q, data_next;
  logic                    mode_q, mode_next;
  logic [COUNT_WIDTH-1:0]  acc, acc_next;
  logic [IDX_WIDTH-1:0]    idx, idx_next;
  logic [COUNT_WIDTH-1:0]  count_next;
  logic                    done_next;
  logic [BITS_PER_CYCLE-1:0] slice_raw, slice_in;
  logic [SLICE_CW-1:0]     slice_ones;
  logic [COUNT_WIDTH-1:0]  acc_sum;

  // Zero counting reuses the ones counter on the inverted slice.
  assign slice_raw = data_q[idx*BITS_PER_CYCLE +: BITS_PER_CYCLE];
  assign slice_in  = (mode_q == MODE_ZEROS) ? ~slice_raw : slice_raw;
  assign acc_sum   = acc + COUNT_WIDTH'(slice_ones);

  bit_count_slice #(
    .WIDTH     (BITS_PER_CYCLE),
    .OUT_WIDTH (SLICE_CW)
  ) u_slice (
    .bits (slice_in),
    .ones (slice_ones)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    data_next  = data_q;
    mode_next  = mode_q;
    acc_next   = acc;
    idx_next   = idx;
    count_next = bit_count;
    done_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
      acc_next   = '0;
      idx_next   = '0;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = SCAN;
            data_next  = data;
            mode_next  = mode;
            acc_next   = '0;
            idx_next   = '0;
          end
        end
        SCAN: begin
          acc_next = acc_sum;
          idx_next = idx + 1'b1;
          if (idx == LAST_IDX) begin
            state_next = IDLE;
            count_next = acc_sum;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      mode_q    <= MODE_ONES;
      acc       <= '0;
      idx       <= '0;
      bit_count <= '0;
      done      <= 1'b0;
    end else begin
      data_q    <= data_next;
      mode_q    <= mode_next;
      acc       <= acc_next;
      idx       <= idx_next;
      bit_count <= count_next;
      done      <= done_next;
    end
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_bit_count_seq.sv
// Directed self-checking bench for bit_count_seq (16-bit, 4 and 1 bits per cycle).
module tb_bit_count_seq;

  logic        clk;
  logic        reset_n;
  logic        start, mode, clear;
  logic [15:0] data;
  logic        busy, done;
  logic [4:0]  bit_count;

  logic        start1, mode1, clear1;
  logic [15:0] data1;
  logic        busy1, done1;
  logic [4:0]  bit_count1;

  int compareCount = 0;
  int errorCount   = 0;

  bit_count_seq #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .data      (data),
    .mode      (mode),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .bit_count (bit_count)
  );

  bit_count_seq #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start1),
    .data      (data1),
    .mode      (mode1),
    .clear     (clear1),
    .busy      (busy1),
    .done      (done1),
    .bit_count (bit_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] d, input logic m, input logic c);
    start = s;
    data  = d;
    mode  = m;
    clear = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start for exactly one edge, which the idle DUT accepts.
  task automatic startOp(input logic [15:0] d, input logic m);
    applyStimulus(1'b1, d, m, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Counts edges from the accepting edge (counted as 1) to the first done cycle.
  task automatic waitDone(output int edges, output int busyCycles);
    edges      = 1;
    busyCycles = busy ? 1 : 0;
    while (!done && edges < 40) begin
      tick();
      edges++;
      if (busy) busyCycles++;
    end
  endtask

  int edges, busyCycles, doneSeen;
  logic [4:0] firstResult;

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    start1 = 1'b0; data1 = 16'h0000; mode1 = 1'b0; clear1 = 1'b0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_count", bit_count, 0);
    reset_n = 1'b1;
    tick();

    $display("[TB] all-ones operand, count ones");
    startOp(16'hFFFF, 1'b0);
    waitDone(edges, busyCycles);
    checkOutput("ffff_latency", edges, 5);
    checkOutput("ffff_busy_cycles", busyCycles, 4);
    checkOutput("ffff_count", bit_count, 16);
    tick();
    checkOutput("ffff_done_width", done, 0);
    checkOutput("ffff_count_hold", bit_count, 16);

    $display("[TB] count zeros, then all-zero operand");
    startOp(16'hA5A1, 1'b1);
    waitDone(edges, busyCycles);
    checkOutput("a5a1_latency", edges, 5);
    checkOutput("a5a1_zeros", bit_count, 9);
    tick();
    startOp(16'h0000, 1'b0);
    waitDone(edges, busyCycles);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_count", bit_count, 0);
    tick();

    $display("[TB] start ignored while busy");
    startOp(16'h000F, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'hFFFF, 1'b1, 1'b0);
    doneSeen = 0;
    firstResult = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) begin
        if (doneSeen == 0) firstResult = bit_count;
        doneSeen++;
      end
    end
    checkOutput("ignore_done_pulses", doneSeen, 1);
    checkOutput("ignore_count", firstResult, 4);
    checkOutput("ignore_idle", busy, 0);

    $display("[TB] back-to-back operation");
    startOp(16'h0003, 1'b0);
    waitDone(edges, busyCycles);
    checkOutput("b2b_first_count", bit_count, 2);
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("b2b_accept_busy", busy, 1);
    waitDone(edges, busyCycles);
    checkOutput("b2b_second_latency", edges, 5);
    checkOutput("b2b_second_count", bit_count, 8);
    tick();

    $display("[TB] clear during scan, clear with start");
    startOp(16'hFFFF, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("clear_busy", busy, 0);
    checkOutput("clear_count", bit_count, 0);
    checkOutput("clear_done", done, 0);
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("clear_no_done", doneSeen, 0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("clear_start_busy", busy, 0);
    tick();
    checkOutput("clear_start_busy_later", busy, 0);
    checkOutput("clear_start_done", done, 0);

    $display("[TB] reset mid-scan");
    startOp(16'h00FF, 1'b0);
    waitDone(edges, busyCycles);
    checkOutput("pre_reset_count", bit_count, 8);
    tick();
    startOp(16'hFFFF, 1'b0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", bit_count, 0);
    tick();
    #3 reset_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("rst_no_done", doneSeen, 0);
    startOp(16'h0F00, 1'b1);
    waitDone(edges, busyCycles);
    checkOutput("post_rst_latency", edges, 5);
    checkOutput("post_rst_count", bit_count, 12);
    tick();

    $display("[TB] one bit per cycle");
    start1 = 1'b1; data1 = 16'hFFFF; mode1 = 1'b0;
    tick();
    start1 = 1'b0; data1 = 16'h0000;
    edges = 1;
    while (!done1 && edges < 40) begin
      tick();
      edges++;
    end
    checkOutput("bpc1_latency", edges, 17);
    checkOutput("bpc1_count", bit_count1, 16);
    tick();
    checkOutput("bpc1_done_width", done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
